// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage with IF/ID pipeline register.
// Keeps the PC, has at most one request outstanding to instruction memory, and
// captures each returned word together with its PC. A word that arrives while
// decode is stalled is parked in a one-entry skid buffer. A branch redirect
// flushes IF/ID and drops any word still in flight.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);

  // FETCH: issue a request; WAIT: response pending; HOLD: skid buffer full
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        discard_reg, discard_next;
  logic [31:0] skid_instr_reg, skid_instr_next;
  logic [31:0] skid_pc_reg, skid_pc_next;
  logic        if_valid_reg, if_valid_next;
  logic [31:0] if_instr_reg, if_instr_next;
  logic [31:0] if_pc_reg, if_pc_next;
  logic [31:0] if_pc_plus4_reg, if_pc_plus4_next;

  // Word offered to IF/ID this cycle (from memory or from the skid buffer)
  logic        load_en;
  logic [31:0] load_instr;
  logic [31:0] load_pc;
  logic        req_raw;

  logic [31:0] target_aligned;
  logic [31:0] pc_plus4;

  // Redirect targets are always word aligned; the PC increment wraps naturally
  assign target_aligned = pc_target & ~32'h0000_0003;
  assign pc_plus4       = pc_reg + 32'd4;

  // State, PC, skid buffer and IF/ID register update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= FETCH;
      pc_reg          <= RESET_PC;
      discard_reg     <= 1'b0;
      skid_instr_reg  <= NOP_INSTR;
      skid_pc_reg     <= 32'd0;
      if_valid_reg    <= 1'b0;
      if_instr_reg    <= NOP_INSTR;
      if_pc_reg       <= 32'd0;
      if_pc_plus4_reg <= 32'd0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      discard_reg     <= discard_next;
      skid_instr_reg  <= skid_instr_next;
      skid_pc_reg     <= skid_pc_next;
      if_valid_reg    <= if_valid_next;
      if_instr_reg    <= if_instr_next;
      if_pc_reg       <= if_pc_next;
      if_pc_plus4_reg <= if_pc_plus4_next;
    end
  end

  // Fetch sequencing: next state, PC, discard flag, skid buffer, request
  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    discard_next    = discard_reg;
    skid_instr_next = skid_instr_reg;
    skid_pc_next    = skid_pc_reg;
    req_raw         = 1'b0;
    load_en         = 1'b0;
    load_instr      = imem_rdata;
    load_pc         = pc_reg;

    case (state_reg)
      FETCH: begin
        // A redirect this cycle suppresses the request to the stale PC
        req_raw = !pc_src;
        if (pc_src) begin
          pc_next = target_aligned;
        end else begin
          state_next = WAIT;
        end
      end

      WAIT: begin
        if (pc_src) begin
          pc_next = target_aligned;
          if (imem_rvalid) begin
            // Word for the old path arrives with the redirect: drop it now
            discard_next = 1'b0;
            state_next   = FETCH;
          end else begin
            // Word still in flight: remember to drop it when it lands
            discard_next = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (discard_reg) begin
            discard_next = 1'b0;
            state_next   = FETCH;
          end else if (!stall) begin
            load_en    = 1'b1;
            load_instr = imem_rdata;
            load_pc    = pc_reg;
            pc_next    = pc_plus4;
            state_next = FETCH;
          end else begin
            skid_instr_next = imem_rdata;
            skid_pc_next    = pc_reg;
            pc_next         = pc_plus4;
            state_next      = HOLD;
          end
        end
      end

      HOLD: begin
        if (pc_src) begin
          // Parked word belongs to the abandoned path
          pc_next    = target_aligned;
          state_next = FETCH;
        end else if (!stall) begin
          load_en    = 1'b1;
          load_instr = skid_instr_reg;
          load_pc    = skid_pc_reg;
          state_next = FETCH;
        end
      end

      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // IF/ID next value: flush on redirect, freeze on stall, else load or bubble
  always_comb begin
    if_valid_next    = if_valid_reg;
    if_instr_next    = if_instr_reg;
    if_pc_next       = if_pc_reg;
    if_pc_plus4_next = if_pc_plus4_reg;

    if (pc_src) begin
      if_valid_next = 1'b0;
      if_instr_next = NOP_INSTR;
    end else if (!stall) begin
      if (load_en) begin
        if_valid_next    = 1'b1;
        if_instr_next    = load_instr;
        if_pc_next       = load_pc;
        if_pc_plus4_next = load_pc + 32'd4;
      end else begin
        if_valid_next = 1'b0;
        if_instr_next = NOP_INSTR;
      end
    end
  end

  // Request is held low for as long as reset is asserted
  assign imem_req    = req_raw & ~rst;
  assign imem_addr   = pc_reg;

  assign if_valid    = if_valid_reg;
  assign if_instr    = if_instr_reg;
  assign if_pc       = if_pc_reg;
  assign if_pc_plus4 = if_pc_plus4_reg;

  // Decoder fields are plain slices of the IF/ID instruction
  assign op     = if_instr_reg[6:0];
  assign rd     = if_instr_reg[11:7];
  assign funct3 = if_instr_reg[14:12];
  assign rs1    = if_instr_reg[19:15];
  assign rs2    = if_instr_reg[24:20];
  assign funct7 = if_instr_reg[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, a few
// hand-written reset sequences, then randomized traffic against a
// transaction-level model of the fetch stage.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .pc_src(pc_src), .pc_target(pc_target),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4),
    .op(op), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        stall;
    logic        src;
    logic [31:0] tgt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t vt[17];

  function automatic vec_t mk(logic s, logic p, logic [31:0] t, logic rv, logic [31:0] d,
                              logic er, logic [31:0] ea, logic ev, logic [31:0] ei,
                              logic [31:0] ep, logic [31:0] ep4);
    vec_t v;
    v.stall = s; v.src = p; v.tgt = t; v.rvalid = rv; v.rdata = d;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei;
    v.e_pc = ep; v.e_pc4 = ep4;
    return v;
  endfunction

  // Compare every output against expected IF/ID contents and request
  task automatic chk_all(input string tag, input logic er, input logic [31:0] ea,
                         input logic ev, input logic [31:0] ei,
                         input logic [31:0] ep, input logic [31:0] ep4);
    chk({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, er});
    chk({tag, ".imem_addr"}, imem_addr, ea);
    chk({tag, ".if_valid"}, {31'd0, if_valid}, {31'd0, ev});
    chk({tag, ".if_instr"}, if_instr, ei);
    chk({tag, ".if_pc"}, if_pc, ep);
    chk({tag, ".if_pc_plus4"}, if_pc_plus4, ep4);
    chk({tag, ".decode"}, {funct7, rs2, rs1, funct3, rd, op}, ei);
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } slot_t;

  slot_t       parked[$];     // word returned while decode was stalled
  logic [31:0] m_pc;
  bit          m_busy;        // a request is outstanding
  bit          m_drop;        // outstanding word belongs to an abandoned path
  logic        m_v;
  logic [31:0] m_instr, m_idpc, m_idpc4;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          loads;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F13;
  endfunction

  task automatic model_reset();
    parked.delete();
    m_pc = 32'h0; m_busy = 0; m_drop = 0;
    m_v = 1'b0; m_instr = NOP; m_idpc = 32'h0; m_idpc4 = 32'h0;
    mem_cnt = 0; mem_addr = 32'h0;
  endtask

  task automatic model_load(input logic [31:0] w, input logic [31:0] a);
    m_v = 1'b1; m_instr = w; m_idpc = a; m_idpc4 = a + 32'd4;
    loads++;
    $display("txn %0d: decode gets instr %h at pc %h", loads, w, a);
  endtask

  // One clock edge of the fetch stage, described by transactions
  task automatic model_step();
    bit got;
    bit loaded;
    slot_t s;
    got = m_busy && imem_rvalid;
    loaded = 0;
    if (pc_src) begin
      m_v = 1'b0; m_instr = NOP;
      parked.delete();
      m_pc = pc_target & ~32'h3;
      if (m_busy && !got) m_drop = 1;
      else begin m_busy = 0; m_drop = 0; end
    end else begin
      if (!m_busy && parked.size() == 0) begin
        m_busy = 1; m_drop = 0;
        mem_addr = m_pc;
        mem_cnt = $urandom_range(1, 3);
      end else if (got) begin
        m_busy = 0;
        if (m_drop) m_drop = 0;
        else if (stall) begin
          s.instr = imem_rdata; s.pc = m_pc;
          parked.push_back(s);
          m_pc = m_pc + 32'd4;
        end else begin
          model_load(imem_rdata, m_pc);
          loaded = 1;
          m_pc = m_pc + 32'd4;
        end
      end else if (parked.size() != 0 && !stall) begin
        s = parked.pop_front();
        model_load(s.instr, s.pc);
        loaded = 1;
      end
      if (!stall && !loaded) begin m_v = 1'b0; m_instr = NOP; end
    end
  endtask

  // Choose this cycle's inputs; memory answers the model's outstanding request
  task automatic pick_inputs();
    stall = ($urandom_range(0, 9) < 3);
    pc_src = ($urandom_range(0, 15) == 0);
    if ($urandom_range(0, 3) == 0) pc_target = 32'hFFFF_FFF0 + $urandom_range(0, 15);
    else pc_target = $urandom;
    imem_rvalid = 1'b0;
    imem_rdata = $urandom;
    if (m_busy) begin
      if (mem_cnt > 0) mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata = mem_word(mem_addr);
      end
    end else begin
      imem_rvalid = ($urandom_range(0, 9) == 0);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; pc_src = 1'b0; pc_target = 32'h0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    loads = 0;

    //            stall src tgt          rv rdata          req addr         v  instr         pc           pc4
    vt[0]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, NOP,          32'h0,       32'h0);
    vt[1]  = mk(0, 0, 32'h0,        1, 32'h00500093, 0, 32'h0,        0, NOP,          32'h0,       32'h0);
    vt[2]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h4,        1, 32'h00500093, 32'h0,       32'h4);
    vt[3]  = mk(0, 0, 32'h0,        1, 32'h00A00113, 0, 32'h4,        0, NOP,          32'h0,       32'h4);
    vt[4]  = mk(1, 0, 32'h0,        0, 32'h0,        1, 32'h8,        1, 32'h00A00113, 32'h4,       32'h8);
    vt[5]  = mk(1, 0, 32'h0,        1, 32'h002081B3, 0, 32'h8,        1, 32'h00A00113, 32'h4,       32'h8);
    vt[6]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'hC,        1, 32'h00A00113, 32'h4,       32'h8);
    vt[7]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'hC,        1, 32'h00A00113, 32'h4,       32'h8);
    vt[8]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'hC,        1, 32'h002081B3, 32'h8,       32'hC);
    vt[9]  = mk(0, 1, 32'h103,      0, 32'h0,        0, 32'hC,        0, NOP,          32'h8,       32'hC);
    vt[10] = mk(0, 0, 32'h0,        1, 32'hDEADBEEF, 0, 32'h100,      0, NOP,          32'h8,       32'hC);
    vt[11] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h100,      0, NOP,          32'h8,       32'hC);
    vt[12] = mk(0, 0, 32'h0,        1, 32'h00C00193, 0, 32'h100,      0, NOP,          32'h8,       32'hC);
    vt[13] = mk(1, 1, 32'hFFFFFFFE, 0, 32'h0,        0, 32'h104,      1, 32'h00C00193, 32'h100,     32'h104);
    vt[14] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'hFFFFFFFC, 0, NOP,          32'h100,     32'h104);
    vt[15] = mk(0, 0, 32'h0,        1, 32'h00100073, 0, 32'hFFFFFFFC, 0, NOP,          32'h100,     32'h104);
    vt[16] = mk(1, 0, 32'h0,        0, 32'h0,        1, 32'h0,        1, 32'h00100073, 32'hFFFFFFFC, 32'h0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h0);
    rst = 1'b0;

    // Directed table: fetch, stall/skid, redirect, flush, PC wrap
    for (int i = 0; i < 17; i++) begin
      stall = vt[i].stall; pc_src = vt[i].src; pc_target = vt[i].tgt;
      imem_rvalid = vt[i].rvalid; imem_rdata = vt[i].rdata;
      #1;
      chk_all($sformatf("vec%0d", i), vt[i].e_req, vt[i].e_addr, vt[i].e_valid,
              vt[i].e_instr, vt[i].e_pc, vt[i].e_pc4);
      $display("vec %0d: req=%b addr=%h valid=%b instr=%h pc=%h", i, imem_req,
               imem_addr, if_valid, if_instr, if_pc);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of WAIT with a valid IF/ID
    stall = 1'b1; pc_src = 1'b0; imem_rvalid = 1'b0;
    #1;
    chk("prerst.if_valid", {31'd0, if_valid}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk_all("asyncrst", 1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h0);
    stall = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAAD_F00D;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk_all("rstrel", 1'b1, 32'h0, 1'b0, NOP, 32'h0, 32'h0);
    @(posedge clk); #1;
    imem_rvalid = 1'b0;
    #1;
    chk_all("stale", 1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h0);
    $display("seq rst: stale response ignored, valid=%b", if_valid);
    @(posedge clk); #1;
    imem_rvalid = 1'b1; imem_rdata = 32'h00500093;
    @(posedge clk); #1;
    imem_rvalid = 1'b0;
    #1;
    chk_all("postrst", 1'b1, 32'h4, 1'b1, 32'h00500093, 32'h0, 32'h4);
    $display("seq rst: first instr %h at pc %h", if_instr, if_pc);

    // Randomized traffic against the reference model
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      pick_inputs();
      #1;
      chk_all($sformatf("rand%0d", c), !m_busy && parked.size() == 0 && !pc_src,
              m_pc, m_v, m_instr, m_idpc, m_idpc4);
      @(posedge clk);
      model_step();
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
